// File: rtl/uart_pkg.sv
// uart_pkg: items shared by the UART receiver and transmitter.
//   rx_state_e : 3-bit FSM state encoding
//   PAR_EVEN / PAR_ODD : parity-mode constants for i_par_odd
//   rx_flags_t : per-word status attributes
//   maj3       : 2-of-3 majority vote
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PAR       = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef struct packed {
    logic par_err;
    logic frm_err;
    logic brk;
    logic overrun;
  } rx_flags_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input synchronizer plus 3-sample majority voter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_rx           : raw asynchronous serial line
//   i_smp          : sample strobe from the FSM (one per sample tick)
//   o_rx_s         : synchronized line
//   o_maj          : majority of the two stored samples and the current o_rx_s,
//                    so it is valid on the third sample tick of a bit
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  input  logic i_smp,
  output logic o_rx_s,
  output logic o_maj
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             smp_q, smp_d;

  assign o_rx_s = sync_q[SYNC_STAGES-1];
  assign o_maj  = maj3(smp_q[1], smp_q[0], o_rx_s);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_rx};
    smp_d  = smp_q;
    if (i_smp) smp_d = {smp_q[0], o_rx_s};
  end

  // Chain resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
      smp_q  <= 2'b11;
    end else begin
      sync_q <= sync_d;
      smp_q  <= smp_d;
    end
  end

endmodule

// File: rtl/uart_rx_fc.sv
// uart_rx_fc: oversampling UART receiver with runtime parity, majority voting,
// false-start rejection, framing/parity/break/overrun flags and a valid/ready
// holding register.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_rx                  : serial line, idle high
//   i_s_tick              : oversample strobe, OSR per bit
//   i_par_en, i_par_odd   : parity present / odd parity, latched at frame start
//   i_ready               : consumer accepts the held word
//   o_valid, o_data       : holding register
//   o_par_err, o_frm_err, o_brk, o_overrun : attributes of o_data
//   o_busy                : FSM not idle
module uart_rx_fc
  import uart_pkg::*;
#(
  parameter int DBITS       = 8,
  parameter int SBITS       = 1,
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  input  logic             i_s_tick,
  input  logic             i_par_en,
  input  logic             i_par_odd,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [DBITS-1:0] o_data,
  output logic             o_par_err,
  output logic             o_frm_err,
  output logic             o_brk,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int SW = $clog2(OSR);
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [SW-1:0] S_LO   = SW'(OSR/2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OSR/2);
  localparam logic [SW-1:0] S_VOTE = SW'(OSR/2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OSR - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);
  localparam logic          STOP_LAST = 1'(SBITS - 1);

  rx_state_e        state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [DBITS-1:0] shreg_q, shreg_d;
  logic             par_bit_q, par_bit_d;
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic             stop_n_q, stop_n_d;
  logic             stop_err_q, stop_err_d;

  logic             valid_q, valid_d;
  logic [DBITS-1:0] data_q, data_d;
  rx_flags_t        flags_q, flags_d;

  logic rx_s, maj;
  logic active, tick_act, smp;
  logic s_vote, s_last;
  logic commit, consume;
  logic frm_err_c, par_err_c, brk_c;

  assign active   = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PAR)   || (state_q == ST_STOP);
  assign tick_act = i_s_tick & active;
  assign s_vote   = (s_q == S_VOTE);
  assign s_last   = (s_q == S_LAST);
  assign smp      = tick_act & ((s_q == S_LO) | (s_q == S_MID) | s_vote);

  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_smp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rx    (i_rx),
    .i_smp   (smp),
    .o_rx_s  (rx_s),
    .o_maj   (maj)
  );

  // Word attributes, evaluated at the vote of the last stop bit.
  assign frm_err_c = stop_err_q | ~maj;
  assign par_err_c = par_en_q & ((^shreg_q ^ par_bit_q) != par_odd_q);
  assign brk_c     = frm_err_c & (shreg_q == '0) & (~par_en_q | ~par_bit_q);

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop_n_d   = stop_n_q;
    stop_err_d = stop_err_q;
    commit     = 1'b0;

    if (tick_act) s_d = s_last ? '0 : s_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          s_d       = '0;
          par_en_d  = i_par_en;
          par_odd_d = i_par_odd;
        end
      end
      ST_START: begin
        if (tick_act) begin
          if (s_vote && maj) begin
            state_d = ST_IDLE;
          end else if (s_last) begin
            state_d = ST_DATA;
            n_d     = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick_act) begin
          if (s_vote) shreg_d = {maj, shreg_q[DBITS-1:1]};
          if (s_last) begin
            if (n_q == N_LAST) begin
              state_d    = par_en_q ? ST_PAR : ST_STOP;
              stop_n_d   = 1'b0;
              stop_err_d = 1'b0;
            end else begin
              n_d = n_q + 1'b1;
            end
          end
        end
      end
      ST_PAR: begin
        if (tick_act) begin
          if (s_vote) par_bit_d = maj;
          if (s_last) begin
            state_d    = ST_STOP;
            stop_n_d   = 1'b0;
            stop_err_d = 1'b0;
          end
        end
      end
      ST_STOP: begin
        if (tick_act) begin
          if (s_vote) begin
            if (stop_n_q == STOP_LAST) begin
              // Leave mid-bit so the next start edge can be caught early.
              commit  = 1'b1;
              state_d = frm_err_c ? ST_WAIT_IDLE : ST_IDLE;
            end else begin
              stop_err_d = frm_err_c;
            end
          end else if (s_last) begin
            stop_n_d = stop_n_q + 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register: consume is applied before a same-cycle commit.
  always_comb begin
    consume = valid_q & i_ready;
    valid_d = valid_q & ~consume;
    data_d  = data_q;
    flags_d = flags_q;
    if (commit) begin
      valid_d         = 1'b1;
      data_d          = shreg_q;
      flags_d.par_err = par_err_c;
      flags_d.frm_err = frm_err_c;
      flags_d.brk     = brk_c;
      flags_d.overrun = valid_q & ~i_ready;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      n_q        <= '0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop_n_q   <= 1'b0;
      stop_err_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop_n_q   <= stop_n_d;
      stop_err_q <= stop_err_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_par_err = flags_q.par_err;
  assign o_frm_err = flags_q.frm_err;
  assign o_brk     = flags_q.brk;
  assign o_overrun = flags_q.overrun;
  assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fc.sv
module tb_uart_rx_fc;
  localparam int DBITS = 8;
  localparam int SBITS = 1;
  localparam int OSR   = 16;
  localparam int SYNC  = 2;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_rx = 1'b1;
  logic             i_s_tick = 1'b0;
  logic             i_par_en = 1'b0;
  logic             i_par_odd = 1'b0;
  logic             i_ready = 1'b1;
  logic             o_valid;
  logic [DBITS-1:0] o_data;
  logic             o_par_err, o_frm_err, o_brk, o_overrun, o_busy;

  uart_rx_fc #(.DBITS(DBITS), .SBITS(SBITS), .OSR(OSR), .SYNC_STAGES(SYNC)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rx      (i_rx),
    .i_s_tick  (i_s_tick),
    .i_par_en  (i_par_en),
    .i_par_odd (i_par_odd),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_par_err (o_par_err),
    .o_frm_err (o_frm_err),
    .o_brk     (o_brk),
    .o_overrun (o_overrun),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // One tick every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(posedge i_clk);
      #1 i_s_tick = 1'b1;
      @(posedge i_clk);
      #1 i_s_tick = 1'b0;
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic       par_err;
    logic       frm_err;
    logic       brk;
    logic       overrun;
  } word_t;

  word_t exp_q[$];
  int total = 0;
  int bad = 0;
  int n_cons = 0;
  int n_vcyc = 0;

  // Monitor: every consumed word is compared with the scoreboard head.
  initial begin
    word_t got, e;
    forever begin
      @(negedge i_clk);
      if (o_valid) n_vcyc++;
      if (o_valid && i_ready) begin
        n_cons++;
        total++;
        got = {o_data, o_par_err, o_frm_err, o_brk, o_overrun};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL word: unexpected word got=%h (data,pe,fe,brk,ovr) none expected", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL word: got=%h required=%h", got, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe,
                      input logic bk, input logic ov);
    word_t w;
    w = {d, pe, fe, bk, ov};
    exp_q.push_back(w);
  endtask

  task automatic wait_tick();
    @(posedge i_clk);
    while (i_s_tick !== 1'b1) @(posedge i_clk);
  endtask

  // Hold the line at v for n ticks; returns just after a tick edge.
  task automatic seg(input logic v, input int n);
    i_rx = v;
    repeat (n) wait_tick();
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic pb);
    seg(1'b0, OSR);
    for (int i = 0; i < DBITS; i++) seg(d[i], OSR);
    if (pen) seg(pb, OSR);
    seg(1'b1, OSR);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge i_clk);
      k++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int c0, v0;
    #21;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_flags", {o_par_err, o_frm_err, o_brk, o_overrun}, 0);
    check("rst_busy", o_busy, 0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    wait_tick(); #1;
    seg(1'b1, 8);

    // Plain frame, valid for exactly one cycle.
    v0 = n_vcyc;
    push(8'hA5, 0, 0, 0, 0);
    send(8'hA5, 1'b0, 1'b0);
    drain("a5_drain");
    check("a5_valid_cycles", n_vcyc - v0, 1);
    check("a5_idle", o_busy, 0);

    // Parity: 0x03 has even ones; parity bit 1 is wrong for even, right for odd.
    i_par_en = 1'b1; i_par_odd = 1'b0;
    push(8'h03, 1, 0, 0, 0);
    send(8'h03, 1'b1, 1'b1);
    drain("par_even_drain");
    i_par_odd = 1'b1;
    push(8'h03, 0, 0, 0, 0);
    send(8'h03, 1'b1, 1'b1);
    drain("par_odd_drain");
    i_par_en = 1'b0; i_par_odd = 1'b0;

    // Short glitch: false start, no word.
    c0 = n_cons;
    seg(1'b0, 5);
    seg(1'b1, OSR);
    check("glitch_busy", o_busy, 0);
    check("glitch_noword", n_cons - c0, 0);
    push(8'h3C, 0, 0, 0, 0);
    send(8'h3C, 1'b0, 1'b0);
    drain("3c_drain");

    // Break: 12 bit-times low, one word then wait for idle.
    c0 = n_cons;
    push(8'h00, 0, 1, 1, 0);
    seg(1'b0, 12 * OSR);
    drain("brk_drain");
    check("brk_wait_busy", o_busy, 1);
    seg(1'b1, 8);
    check("brk_idle", o_busy, 0);
    seg(1'b1, 2 * OSR);
    check("brk_one_word", n_cons - c0, 1);

    // 0x00 with a one-tick high spike at the centre of bit 3.
    push(8'h00, 0, 0, 0, 0);
    seg(1'b0, OSR);
    for (int i = 0; i < 3; i++) seg(1'b0, OSR);
    seg(1'b0, OSR/2); seg(1'b1, 1); seg(1'b0, OSR/2 - 1);
    for (int i = 4; i < DBITS; i++) seg(1'b0, OSR);
    seg(1'b1, OSR);
    drain("spike_drain");

    // Overrun: two frames unread.
    i_ready = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    check("ovr_valid", o_valid, 1);
    check("ovr_data", o_data, 8'h22);
    check("ovr_flag", o_overrun, 1);
    push(8'h22, 0, 0, 0, 1);
    i_ready = 1'b1;
    drain("ovr_drain");
    @(negedge i_clk);
    check("ovr_valid_clear", o_valid, 0);

    // Reset in the middle of DATA.
    #1;
    seg(1'b0, OSR); seg(1'b1, OSR); seg(1'b0, OSR); seg(1'b1, OSR/2);
    check("mid_busy", o_busy, 1);
    i_rst_n = 1'b0;
    #2;
    check("mrst_out", {o_valid, o_data, o_par_err, o_frm_err, o_brk, o_overrun}, 0);
    check("mrst_busy", o_busy, 0);
    i_rx = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    wait_tick(); #1;
    seg(1'b1, OSR);
    c0 = n_cons;
    push(8'h55, 0, 0, 0, 0);
    send(8'h55, 1'b0, 1'b0);
    drain("55_drain");
    check("55_one_word", n_cons - c0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_fc.md
# uart_rx_fc

Oversampling UART receiver with runtime parity mode, 3-sample majority voting, false-start rejection, framing/parity/break/overrun detection and a valid/ready output holding register. It sits between the pad-side `rx` line and the UART host FIFO. It shares the baud-rate generator tick `i_s_tick` with the transmitter.

## Interface
- `DBITS`, 8, data bits per frame, 5..9, LSB first
- `SBITS`, 1, stop bits, 1 or 2
- `OSR`, 16, ticks per bit, even, ≥ 8
- `SYNC_STAGES`, 2, input synchronizer depth, ≥ 2
- Reset: `i_rst_n` is asynchronous, active-low. Clock: `i_clk`.
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  async active-low reset
- `i_rx`  in  1  serial line, asynchronous, idle high
- `i_s_tick`  in  1  oversample strobe, one `i_clk` wide, OSR per bit
- `i_par_en`  in  1  parity bit present
- `i_par_odd`  in  1  1 = odd, 0 = even parity
- `i_ready`  in  1  consumer accepts word
- `o_valid`  out  1  holding register full
- `o_data`  out  DBITS  received data
- `o_par_err`  out  1  parity mismatch for `o_data`
- `o_frm_err`  out  1  a stop bit was sampled 0
- `o_brk`  out  1  break: all data, parity and stop samples 0
- `o_overrun`  out  1  an unread word was overwritten by this word
- `o_busy`  out  1  FSM not in IDLE

## Operation
- `i_rx` passes through a `SYNC_STAGES` flop chain; the chain resets to 1. The FSM sees only the synced `rx_s`.
- Bit value is the majority of `rx_s` at ticks `s` = OSR/2-1, OSR/2 and OSR/2+1 of the bit. `s` counts 0..OSR-1 on `i_s_tick`.
- `i_par_en` and `i_par_odd` are latched on the IDLE→START transition and held for the whole frame.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
  - IDLE: `rx_s`=0 → START, `s`=0. No tick is required.
  - START: at `s`=OSR/2+1, if the majority is 1 → IDLE (false start, no output). Otherwise, at `s`=OSR-1 → DATA, `n`=0.
  - DATA: at `s`=OSR/2+1, shift the voted bit into the MSB (LSB-first). At `s`=OSR-1, if `n`=DBITS-1 → PAR if parity is enabled, else STOP; otherwise `n`++.
  - PAR: store the voted bit. Error if XOR(data, parity bit) ≠ `i_par_odd`. At `s`=OSR-1 → STOP.
  - STOP: check each stop bit's vote. On the last stop bit at `s`=OSR/2+1, commit the frame:
    - if no stop error → IDLE
    - if any stop error → WAIT_IDLE
  - Exiting mid-bit is deliberate: it tolerates ±½-bit drift and back-to-back frames.
  - WAIT_IDLE: stay until `rx_s`=1, then → IDLE.
- Commit: load `o_data` and all flags, set `o_valid`. `o_brk` = frm_err AND data==0 AND (parity disabled OR parity bit 0).
- `o_overrun` = `o_valid` was 1 at commit and was not consumed in that cycle.
- Handshake: a word is consumed when `o_valid` & `i_ready`; `o_valid` clears the next cycle. If commit and consume happen in the same cycle, consume happens first, `o_overrun`=0, and the new word is loaded.
- The flags are word attributes. They hold with `o_data` until the next commit.
- Reset mid-frame: the FSM goes to IDLE and any partial frame is discarded.

## Timing
- Every output resets to 0, and `o_data` resets to 0.
- Latency: `o_valid` rises 1 `i_clk` after the tick at STOP `s`=OSR/2+1. The line-to-FSM delay is SYNC_STAGES clocks.
- Frame length seen by the FSM: 1 + DBITS + par + (SBITS−1) full bits, plus OSR/2+2 ticks of the last stop bit.
- Counter widths: `s` is $clog2(OSR) bits, `n` is $clog2(DBITS) bits (minimum 1). There is no wrap beyond OSR-1 or DBITS-1.
- `i_s_tick` is ignored in IDLE and WAIT_IDLE. Without ticks the FSM holds its state.

## Structure
- `uart_pkg`: FSM state localparams (3 bits) and the parity-mode constants. These are shared with the transmitter.
- Sub-module `uart_rx_sampler`: synchronizer, a 3-sample shift register and the majority output. Its input is `s` (or a sample strobe) from the FSM.
- The top contains the FSM, counters, shift register, parity accumulator and holding register.

## Test plan
All cases use DBITS=8, OSR=16, SBITS=1.
- Frame 0xA5, no parity, `i_ready`=1 → `o_data`=0xA5, `o_valid` for 1 cycle, all flags 0.
- Even parity with data 0x03 and parity bit 1 → `o_par_err`=1. Same frame with `i_par_odd`=1 → `o_par_err`=0.
- 5-tick low glitch on idle line → no `o_valid`. Returns to IDLE with `o_busy`=0. The next 0x3C is received correctly.
- Line low for 12 bit-times → one word: `o_data`=0x00, `o_frm_err`=1, `o_brk`=1. No further word until the line is high and then a new start.
- Data 0x00 with `i_rx` forced high for 1 tick at the centre of bit 3 → majority vote gives `o_data`=0x00.
- Two frames 0x11 then 0x22 with `i_ready`=0 → `o_data`=0x22, `o_overrun`=1. Assert reset mid-DATA of a third frame → all outputs 0, and the following 0x55 is received clean.
